// File: rtl/memory_cycle_pkg.sv
// Shared types and constants for the memory stage: FSM state encoding and load funct3 codes.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package memory_cycle_pkg;

    // Memory-handshake FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } mem_state_e;

    // Load funct3 codes carried in ALUSelect[2:0]
    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

endpackage

// File: rtl/memory_cycle_load_converter.sv
// Load data extension: sign/zero-extends the low byte/half of the raw memory word by funct3.
// Latency: combinational.
// Backpressure: none, pure function of its inputs.
module LoadConverter
    import memory_cycle_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rawData,
    input  logic [2:0]      aluSelect,
    output logic [XLEN-1:0] outputData
);

    // Pick the lane width and extension mode; data always comes from the low lanes
    always_comb begin
        outputData = rawData;
        case (aluSelect)
            LB:      outputData = {{(XLEN-8){rawData[7]}}, rawData[7:0]};
            LH:      outputData = {{(XLEN-16){rawData[15]}}, rawData[15:0]};
            LW:      outputData = rawData;
            LBU:     outputData = {{(XLEN-8){1'b0}}, rawData[7:0]};
            LHU:     outputData = {{(XLEN-16){1'b0}}, rawData[15:0]};
            default: outputData = rawData;
        endcase
    end

endmodule

// File: rtl/memory_cycle.sv
// Memory pipeline stage: EX/MEM register, data-memory handshake FSM, load extension, MEM/WB register.
// Latency: one cycle EX/MEM capture, plus memory wait cycles, plus one cycle into MEM/WB.
// Backpressure: StallM holds upstream while a request is outstanding or during the post-access gap.
module memory_cycle
    import memory_cycle_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] ALUOutM,
    input  logic [XLEN-1:0] PCPlusImmM,
    input  logic [XLEN-1:0] StoreCounterOutM,
    input  logic [5:0]      ALUSelectM,
    input  logic [4:0]      WriteAddressM,
    input  logic            JtypeM,
    input  logic            RegWriteM,
    input  logic            MemReadM,
    input  logic            MemWriteM,
    input  logic            BranchM,
    output logic            mem_read,
    output logic            mem_write,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_writedata,
    input  logic [XLEN-1:0] mem_readdata,
    input  logic            mem_busywait,
    output logic            StallM,
    output logic [XLEN-1:0] ALUOutfromM,
    output logic [4:0]      RdM2FU,
    output logic            RegWriteM2FU,
    output logic [XLEN-1:0] PCPlusImmW,
    output logic [XLEN-1:0] ALUOutW,
    output logic [XLEN-1:0] ReadDataW,
    output logic [4:0]      WriteAddressW,
    output logic            RegWriteW,
    output logic            MemReadW,
    output logic            JtypeW,
    output logic            BranchW
);

    // EX/MEM register contents
    logic [XLEN-1:0] aluout_q, pcimm_q, store_q;
    logic [5:0]      alusel_q;
    logic [4:0]      rd_q;
    logic            jtype_q, regwrite_q, memread_q, memwrite_q, branch_q;

    // MEM/WB register contents
    logic [XLEN-1:0] pcimm_w_q, aluout_w_q, rdata_w_q;
    logic [4:0]      rd_w_q;
    logic            regwrite_w_q, memread_w_q, jtype_w_q, branch_w_q;

    mem_state_e      state_q;

    logic            mem_op;
    logic            req;
    logic            done;
    logic            next_is_mem;
    logic [XLEN-1:0] load_data_d;
    logic            unused_sel;

    // Only funct3 drives extension; the upper select bits ride along in EX/MEM unused here
    assign unused_sel = ^alusel_q[5:3];

    LoadConverter #(.XLEN(XLEN)) u_load_conv (
        .rawData    (mem_readdata),
        .aluSelect  (alusel_q[2:0]),
        .outputData (load_data_d)
    );

    // Request strobes, completion and stall; the gap cycle suppresses the request but keeps stalling
    always_comb begin
        mem_op      = memread_q | memwrite_q;
        mem_read    = memread_q  & (state_q != GAP);
        mem_write   = memwrite_q & (state_q != GAP);
        req         = mem_read | mem_write;
        done        = req & ~mem_busywait;
        StallM      = mem_op & ~done;
        next_is_mem = MemReadM | MemWriteM;
    end

    assign mem_addr      = aluout_q;
    assign mem_writedata = store_q;
    assign ALUOutfromM   = aluout_q;
    assign RdM2FU        = rd_q;
    assign RegWriteM2FU  = regwrite_q;

    assign PCPlusImmW    = pcimm_w_q;
    assign ALUOutW       = aluout_w_q;
    assign ReadDataW     = rdata_w_q;
    assign WriteAddressW = rd_w_q;
    assign RegWriteW     = regwrite_w_q;
    assign MemReadW      = memread_w_q;
    assign JtypeW        = jtype_w_q;
    assign BranchW       = branch_w_q;

    // EX/MEM register: capture the execute-stage bundle unless the stage is stalled
    always_ff @(posedge clk) begin
        if (!reset) begin
            aluout_q   <= '0;
            pcimm_q    <= '0;
            store_q    <= '0;
            alusel_q   <= '0;
            rd_q       <= '0;
            jtype_q    <= 1'b0;
            regwrite_q <= 1'b0;
            memread_q  <= 1'b0;
            memwrite_q <= 1'b0;
            branch_q   <= 1'b0;
        end else if (!StallM) begin
            aluout_q   <= ALUOutM;
            pcimm_q    <= PCPlusImmM;
            store_q    <= StoreCounterOutM;
            alusel_q   <= ALUSelectM;
            rd_q       <= WriteAddressM;
            jtype_q    <= JtypeM;
            regwrite_q <= RegWriteM;
            memread_q  <= MemReadM;
            memwrite_q <= MemWriteM;
            branch_q   <= BranchM;
        end
    end

    // Handshake FSM: wait out busywait, then insert one request-low cycle before a following access
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req && mem_busywait) begin
                        state_q <= BUSY;
                    end else if (done) begin
                        state_q <= next_is_mem ? GAP : IDLE;
                    end
                end
                BUSY: begin
                    if (done) begin
                        state_q <= next_is_mem ? GAP : IDLE;
                    end else if (!req) begin
                        state_q <= IDLE;
                    end
                end
                GAP:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // MEM/WB register: advance on completion or non-memory ops, otherwise inject a bubble
    always_ff @(posedge clk) begin
        if (!reset) begin
            pcimm_w_q    <= '0;
            aluout_w_q   <= '0;
            rdata_w_q    <= '0;
            rd_w_q       <= '0;
            regwrite_w_q <= 1'b0;
            memread_w_q  <= 1'b0;
            jtype_w_q    <= 1'b0;
            branch_w_q   <= 1'b0;
        end else if (StallM) begin
            regwrite_w_q <= 1'b0;
            memread_w_q  <= 1'b0;
            jtype_w_q    <= 1'b0;
            branch_w_q   <= 1'b0;
        end else begin
            pcimm_w_q    <= pcimm_q;
            aluout_w_q   <= aluout_q;
            rdata_w_q    <= load_data_d;
            rd_w_q       <= rd_q;
            regwrite_w_q <= regwrite_q;
            memread_w_q  <= memread_q;
            jtype_w_q    <= jtype_q;
            branch_w_q   <= branch_q;
        end
    end

endmodule

// File: tb/tb_memory_cycle.sv
// Directed bench for memory_cycle with a writeback scoreboard.
// Latency: n/a.
// Backpressure: n/a.
module tb_memory_cycle;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] ALUOutM = '0, PCPlusImmM = '0, StoreCounterOutM = '0;
    logic [5:0]  ALUSelectM = '0;
    logic [4:0]  WriteAddressM = '0;
    logic        JtypeM = 1'b0, RegWriteM = 1'b0, MemReadM = 1'b0, MemWriteM = 1'b0, BranchM = 1'b0;
    logic        mem_read, mem_write;
    logic [31:0] mem_addr, mem_writedata;
    logic [31:0] mem_readdata = '0;
    logic        mem_busywait = 1'b0;
    logic        StallM;
    logic [31:0] ALUOutfromM;
    logic [4:0]  RdM2FU;
    logic        RegWriteM2FU;
    logic [31:0] PCPlusImmW, ALUOutW, ReadDataW;
    logic [4:0]  WriteAddressW;
    logic        RegWriteW, MemReadW, JtypeW, BranchW;

    memory_cycle #(.XLEN(32)) dut (
        .clk              (clk),
        .reset            (reset),
        .ALUOutM          (ALUOutM),
        .PCPlusImmM       (PCPlusImmM),
        .StoreCounterOutM (StoreCounterOutM),
        .ALUSelectM       (ALUSelectM),
        .WriteAddressM    (WriteAddressM),
        .JtypeM           (JtypeM),
        .RegWriteM        (RegWriteM),
        .MemReadM         (MemReadM),
        .MemWriteM        (MemWriteM),
        .BranchM          (BranchM),
        .mem_read         (mem_read),
        .mem_write        (mem_write),
        .mem_addr         (mem_addr),
        .mem_writedata    (mem_writedata),
        .mem_readdata     (mem_readdata),
        .mem_busywait     (mem_busywait),
        .StallM           (StallM),
        .ALUOutfromM      (ALUOutfromM),
        .RdM2FU           (RdM2FU),
        .RegWriteM2FU     (RegWriteM2FU),
        .PCPlusImmW       (PCPlusImmW),
        .ALUOutW          (ALUOutW),
        .ReadDataW        (ReadDataW),
        .WriteAddressW    (WriteAddressW),
        .RegWriteW        (RegWriteW),
        .MemReadW         (MemReadW),
        .JtypeW           (JtypeW),
        .BranchW          (BranchW)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        is_load;
    } wb_t;

    wb_t sb[$];
    int  checks = 0;
    int  errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Every register writeback must match the oldest expected entry
    task automatic wb_check();
        wb_t e;
        if (RegWriteW === 1'b1) begin
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL wb_unexpected observed rd=%0d data=0x%08h expected=no writeback",
                       WriteAddressW, ReadDataW);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("wb_rd", {27'd0, WriteAddressW}, {27'd0, e.rd});
                chkb("wb_memread", MemReadW, e.is_load);
                if (e.is_load) chk("wb_readdata", ReadDataW, e.data);
                else           chk("wb_aluout", ALUOutW, e.data);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        wb_check();
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drive(input logic [5:0] sel, input logic [31:0] alu, input logic [31:0] sd,
                         input logic [4:0] rd, input logic rw, input logic mr, input logic mw);
        ALUSelectM       = sel;
        ALUOutM          = alu;
        PCPlusImmM       = alu + 32'd4;
        StoreCounterOutM = sd;
        WriteAddressM    = rd;
        RegWriteM        = rw;
        MemReadM         = mr;
        MemWriteM        = mw;
        JtypeM           = 1'b0;
        BranchM          = 1'b0;
    endtask

    task automatic nop();
        drive(6'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // Single zero-wait load surrounded by non-memory cycles
    task automatic zero_wait_load(input string tag, input logic [2:0] f3, input logic [31:0] rdata,
                                  input logic [4:0] rd, input logic [31:0] exp);
        wb_t e;
        mem_readdata = rdata;
        drive({3'b000, f3}, 32'h0000_0200, 32'd0, rd, 1'b1, 1'b1, 1'b0);
        e.rd = rd; e.data = exp; e.is_load = 1'b1;
        sb.push_back(e);
        tick();
        nop();
        settle();
        chkb({tag, "_req"}, mem_read, 1'b1);
        chkb({tag, "_nostall"}, StallM, 1'b0);
        tick();
    endtask

    initial begin
        wb_t e;
        int  stalls;

        // Reset
        nop();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        settle();
        chkb("rst_mem_read", mem_read, 1'b0);
        chkb("rst_mem_write", mem_write, 1'b0);
        chkb("rst_stall", StallM, 1'b0);
        chkb("rst_regwritew", RegWriteW, 1'b0);
        chk("rst_readdataw", ReadDataW, 32'd0);
        chk("rst_aluoutw", ALUOutW, 32'd0);
        chk("rst_rdw", {27'd0, WriteAddressW}, 32'd0);

        // ADD while busywait floats high with no memory op in flight
        mem_busywait = 1'b1;
        drive(6'd0, 32'h0000_1234, 32'd0, 5'd5, 1'b1, 1'b0, 1'b0);
        e.rd = 5'd5; e.data = 32'h0000_1234; e.is_load = 1'b0;
        sb.push_back(e);
        settle();
        chkb("busy_noreq_stall", StallM, 1'b0);
        tick();
        nop();
        settle();
        chk("add_fwd_alu", ALUOutfromM, 32'h0000_1234);
        chk("add_fwd_rd", {27'd0, RdM2FU}, 32'd5);
        chkb("add_fwd_rw", RegWriteM2FU, 1'b1);
        chkb("add_no_read", mem_read, 1'b0);
        chkb("add_no_write", mem_write, 1'b0);
        chkb("add_no_stall", StallM, 1'b0);
        tick();
        chkb("add_wb_rw", RegWriteW, 1'b1);

        // LW with three busywait cycles
        mem_readdata = 32'hDEAD_BEEF;
        drive(6'b000010, 32'h0000_0040, 32'd0, 5'd7, 1'b1, 1'b1, 1'b0);
        e.rd = 5'd7; e.data = 32'hDEAD_BEEF; e.is_load = 1'b1;
        sb.push_back(e);
        tick();
        nop();
        settle();
        chk("lw_addr", mem_addr, 32'h0000_0040);
        chkb("lw_req", mem_read, 1'b1);
        stalls = 0;
        for (int i = 0; i < 3; i++) begin
            if (StallM === 1'b1) stalls++;
            tick();
            settle();
        end
        mem_busywait = 1'b0;
        settle();
        chk("lw_stall_cycles", stalls, 32'd3);
        chkb("lw_done_nostall", StallM, 1'b0);
        tick();
        chkb("lw_wb_rw", RegWriteW, 1'b1);
        chk("lw_wb_data", ReadDataW, 32'hDEAD_BEEF);
        tick();
        chkb("lw_wb_once", RegWriteW, 1'b0);

        // LB then LBU back-to-back, zero-wait
        mem_readdata = 32'h0000_0080;
        drive(6'b000000, 32'h0000_0080, 32'd0, 5'd8, 1'b1, 1'b1, 1'b0);
        e.rd = 5'd8; e.data = 32'hFFFF_FF80; e.is_load = 1'b1;
        sb.push_back(e);
        tick();
        drive(6'b000100, 32'h0000_0084, 32'd0, 5'd9, 1'b1, 1'b1, 1'b0);
        e.rd = 5'd9; e.data = 32'h0000_0080; e.is_load = 1'b1;
        sb.push_back(e);
        settle();
        chkb("lb_req", mem_read, 1'b1);
        chkb("lb_nostall", StallM, 1'b0);
        tick();
        nop();
        settle();
        chkb("lb_gap_req", mem_read, 1'b0);
        chkb("lb_gap_stall", StallM, 1'b1);
        tick();
        chkb("lbu_req", mem_read, 1'b1);
        chkb("lbu_nostall", StallM, 1'b0);
        tick();

        // SW then LW back-to-back, zero-wait
        drive(6'b001010, 32'h0000_0100, 32'hCAFE_F00D, 5'd0, 1'b0, 1'b0, 1'b1);
        tick();
        mem_readdata = 32'h1122_3344;
        drive(6'b000010, 32'h0000_0100, 32'd0, 5'd10, 1'b1, 1'b1, 1'b0);
        e.rd = 5'd10; e.data = 32'h1122_3344; e.is_load = 1'b1;
        sb.push_back(e);
        settle();
        chkb("sw_write", mem_write, 1'b1);
        chkb("sw_no_read", mem_read, 1'b0);
        chk("sw_data", mem_writedata, 32'hCAFE_F00D);
        chk("sw_addr", mem_addr, 32'h0000_0100);
        chkb("sw_nostall", StallM, 1'b0);
        tick();
        nop();
        settle();
        chkb("gap_write", mem_write, 1'b0);
        chkb("gap_read", mem_read, 1'b0);
        chkb("gap_stall", StallM, 1'b1);
        tick();
        chkb("lw2_read", mem_read, 1'b1);
        chkb("lw2_write", mem_write, 1'b0);
        chkb("lw2_nostall", StallM, 1'b0);
        tick();
        chkb("lw2_after_read", mem_read, 1'b0);

        // Extension corner cases
        zero_wait_load("lh", 3'b001, 32'h1234_8001, 5'd11, 32'hFFFF_8001);
        zero_wait_load("lhu", 3'b101, 32'h1234_8001, 5'd12, 32'h0000_8001);
        zero_wait_load("lh_pos", 3'b001, 32'hFFFF_7001, 5'd13, 32'h0000_7001);
        zero_wait_load("lb_pos", 3'b000, 32'hFFFF_FF7F, 5'd14, 32'h0000_007F);
        zero_wait_load("f3_011", 3'b011, 32'h8765_4321, 5'd15, 32'h8765_4321);

        // Reset during BUSY abandons the load
        mem_readdata = 32'h5555_AAAA;
        mem_busywait = 1'b1;
        drive(6'b000010, 32'h0000_0300, 32'd0, 5'd16, 1'b1, 1'b1, 1'b0);
        tick();
        nop();
        tick();
        settle();
        chkb("busy_req", mem_read, 1'b1);
        chkb("busy_stall", StallM, 1'b1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        settle();
        chkb("abort_req", mem_read, 1'b0);
        chkb("abort_stall", StallM, 1'b0);
        chkb("abort_rw", RegWriteW, 1'b0);
        tick();
        chkb("abort_no_wb", RegWriteW, 1'b0);

        // Back in IDLE: a zero-wait load completes with no stall
        mem_busywait = 1'b0;
        zero_wait_load("post_abort", 3'b010, 32'h0BAD_F00D, 5'd17, 32'h0BAD_F00D);
        tick();
        tick();

        chk("sb_drained", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
